// File: rtl/mult_result_collector_if.sv
// Operand and result handshake bundle for mult_result_collector.
// The slave side is the collector; the master side is the producer/consumer.
interface mult_result_collector_if #(
  parameter int TAG_W = 4
) ();
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_a;
  logic [31:0]       in_b;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_r;
  logic [TAG_W-1:0]  out_tag;

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_r, out_tag
  );

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_r, out_tag
  );
endinterface

// File: rtl/mult_result_collector.sv
// Issues operand pairs to an external fixed-latency multiplier, tracks them with a
// valid/tag pipeline and buffers products in a credit-protected in-order FIFO.
module mult_result_collector #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mult_result_collector_if.slave bus,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_r,
  output logic        busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = $clog2(DEPTH + LATENCY + 1);

  logic              vld_q [LATENCY];
  logic [TAG_W-1:0]  tag_q [LATENCY];
  logic [63:0]       mem_r_q   [DEPTH];
  logic [TAG_W-1:0]  mem_tag_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run_q;

  logic [SUM_W-1:0]  inflight;
  logic [SUM_W-1:0]  credit_used;
  logic              issue, capture, pop;

  // Credits count both buffered results and results still inside the multiplier,
  // so every capture is guaranteed a free slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + SUM_W'(vld_q[i]);
    end
    credit_used = inflight + SUM_W'(cnt_q);
  end

  assign bus.in_ready  = run_q && (credit_used < SUM_W'(DEPTH));
  assign bus.out_valid = (cnt_q != '0);
  assign bus.out_r     = mem_r_q[rd_ptr_q];
  assign bus.out_tag   = mem_tag_q[rd_ptr_q];
  assign busy          = (inflight != '0) || (cnt_q != '0);

  assign mul_a   = bus.in_a;
  assign mul_b   = bus.in_b;
  assign issue   = bus.in_valid && bus.in_ready;
  assign capture = vld_q[LATENCY-1];
  assign pop     = bus.out_valid && bus.out_ready;

  always_comb begin
    cnt_d = cnt_q;
    case ({capture, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // in_ready is held low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= issue;
      tag_q[0] <= bus.in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r_q[i]   <= '0;
        mem_tag_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (capture) begin
        mem_r_q[wr_ptr_q]   <= mul_r;
        mem_tag_q[wr_ptr_q] <= tag_q[LATENCY-1];
        wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      cnt_q <= cnt_d;
    end
  end

endmodule
